// File: rtl/des_sbox_pkg.sv
// des_sbox_pkg: FIPS 46-3 S-box and P tables, engine FSM states and lookup helper.
package des_sbox_pkg;
    typedef logic [5:0] sbox_addr_t;
    typedef logic [3:0] sbox_nib_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    // Each box holds its four rows back to back: entry = row*16 + col, leftmost hex digit is entry 0.
    localparam logic [0:7][0:63][3:0] SBOX = '{
        {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };
    localparam int P_TABLE [0:31] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
    };
    function automatic sbox_nib_t sbox_lookup(input logic [2:0] idx, input sbox_addr_t addr);
        return SBOX[idx][{addr[5], addr[0], addr[4:1]}];
    endfunction
endpackage

// File: rtl/des_sbox_lut.sv
// des_sbox_lut: combinational single S-box lookup, box index and 6-bit address to nibble.
import des_sbox_pkg::*;
module des_sbox_lut (
    input  logic [2:0] idx,
    input  sbox_addr_t addr,
    output sbox_nib_t  nib
);
    assign nib = sbox_lookup(idx, addr);
endmodule

// File: rtl/des_sbox_engine.sv
// des_sbox_engine: time-multiplexed DES S1..S8 substitution, LANES boxes per clock, valid/ready on both sides.
// Define DES_SBOX_P_PERM_EN to register P(S1..S8) on dout instead of the raw concatenation.
import des_sbox_pkg::*;
module des_sbox_engine #(
    parameter int LANES = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [47:0]      din,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      dout,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int NGRP = 8 / LANES;
    localparam int GW   = 4 * LANES;
    localparam int CW   = NGRP > 1 ? $clog2(NGRP) : 1;
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end
    state_t           state, state_nx;
    logic [CW-1:0]    grp_cnt;
    logic [47:0]      din_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      result, acc, load;
    logic [GW-1:0]    nibs;
    logic             last;
    assign last = grp_cnt == CW'(NGRP - 1);
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [2:0] box;
        assign box = 3'(int'(grp_cnt) * LANES + j);
        des_sbox_lut u_lut (
            .idx (box),
            .addr(6'(din_q >> (6 * (7 - int'(box))))),
            .nib (nibs[GW-1-4*j -: 4])
        );
    end
    // Result is cleared on accept, so each group only has to OR its nibbles into place.
    assign acc = result | ((32'(nibs) << (32 - GW)) >> (GW * int'(grp_cnt)));
`ifdef DES_SBOX_P_PERM_EN
    for (genvar i = 0; i < 32; i++) begin : g_perm
        assign load[31-i] = acc[32-P_TABLE[i]];
    end
`else
    assign load = acc;
`endif
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = in_valid ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grp_cnt <= '0;
            din_q   <= '0;
            tag_q   <= '0;
            result  <= '0;
            dout    <= '0;
        end else begin
            state <= state_nx;
            if (in_valid && state == IDLE) begin
                din_q   <= din;
                tag_q   <= in_tag;
                grp_cnt <= '0;
                result  <= '0;
            end
            if (state == RUN) begin
                result  <= acc;
                grp_cnt <= last ? '0 : grp_cnt + 1'b1;
                if (last) dout <= load;
            end
        end
    end
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign out_tag   = tag_q;
endmodule

// File: tb/tb_des_sbox_engine.sv
// tb_des_sbox_engine: four engines (LANES 1/2/4/8) checked against a table-driven DES S-box/P model.
module tb_des_sbox_engine;
    localparam int TAG_W = 4;
    localparam int S_TAB [8][4][16] = '{
        '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
          '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
        '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
          '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
        '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
          '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
        '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
          '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
        '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
          '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
        '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
          '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
        '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
          '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
        '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
          '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
    };
    localparam int P_TAB [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int LAT [4] = '{9, 5, 3, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid [4], in_ready [4], out_valid [4], out_ready [4], busy [4];
    logic [47:0] din [4];
    logic [TAG_W-1:0] in_tag [4], out_tag [4];
    logic [31:0] dout [4];
    int n_chk = 0, n_fail = 0, cyc = 0;
    bit rnd_mode = 1'b0, end_chk = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Box b reads bits 47-6b..42-6b; row from the outer two bits, column from the middle four.
    function automatic logic [31:0] model_raw(input logic [47:0] d);
        logic [31:0] r = '0;
        for (int b = 0; b < 8; b++) begin
            int a = int'((d >> (42 - 6 * b)) & 48'h3F);
            r = (r << 4) | 32'(S_TAB[b][(a / 32) * 2 + (a % 2)][(a / 2) % 16]);
        end
        return r;
    endfunction

    // Output bit i (1 = MSB) takes input bit P_TAB[i-1].
    function automatic logic [31:0] model_p(input logic [31:0] s);
        logic [31:0] r = '0;
        for (int i = 0; i < 32; i++) r = (r << 1) | ((s >> (32 - P_TAB[i])) & 32'h1);
        return r;
    endfunction

    function automatic logic [31:0] dout_of(input logic [31:0] raw);
`ifdef DES_SBOX_P_PERM_EN
        return model_p(raw);
`else
        return raw;
`endif
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int NG = 8 >> k;
        logic [TAG_W+31:0] q [$];
        int acc_cyc = 0, prev_acc = -100;
        bit pend = 1'b0, ov_d = 1'b0;
        des_sbox_engine #(.LANES(1 << k), .TAG_W(TAG_W)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid[k]), .in_ready(in_ready[k]), .din(din[k]),
            .in_tag(in_tag[k]), .out_valid(out_valid[k]), .out_ready(out_ready[k]), .dout(dout[k]),
            .out_tag(out_tag[k]), .busy(busy[k])
        );
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                pend = 1'b0;
                ov_d = 1'b0;
                prev_acc = -100;
            end else begin
                check($sformatf("busy_ready%0d", k), {busy[k], in_ready[k]}, {pend, !pend});
                if (out_valid[k]) begin
                    check($sformatf("out_expected%0d", k), q.size() > 0, 1);
                    if (q.size() > 0) check($sformatf("out_word%0d", k), {out_tag[k], dout[k]}, q[0]);
                    if (!ov_d) check($sformatf("latency%0d", k), cyc - acc_cyc, NG + 1);
                    if (out_ready[k]) begin
                        if (q.size() > 0) void'(q.pop_front());
                        pend = 1'b0;
                    end
                end
                if (in_valid[k] && in_ready[k]) begin
                    check($sformatf("issue_gap%0d", k), cyc - prev_acc >= NG + 2, 1);
                    q.push_back({in_tag[k], dout_of(model_raw(din[k]))});
                    pend = 1'b1;
                    acc_cyc = cyc;
                    prev_acc = cyc;
                end
                ov_d = out_valid[k];
            end
        end
        initial begin
            wait (end_chk);
            check($sformatf("drained%0d", k), q.size(), 0);
        end
    end

    task automatic send(input int k, input logic [47:0] d, input logic [TAG_W-1:0] t);
        int n = 0;
        in_valid[k] = 1'b1;
        din[k] = d;
        in_tag[k] = t;
        @(negedge clk);
        while (!in_ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("send_ready%0d", k), in_ready[k], 1);
        @(posedge clk);
        #1 in_valid[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid[k] && n < 40);
    endtask

    task automatic check_reset(input int k);
        check($sformatf("reset_state%0d", k), {out_valid[k], in_ready[k], busy[k], out_tag[k], dout[k]},
              {1'b0, 1'b1, 1'b0, 4'h0, 32'h0});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d assertions evaluated", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) for (int k = 0; k < 4; k++) out_ready[k] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int lat, seen;
        logic [47:0] rd;
        for (int k = 0; k < 4; k++) begin
            in_valid[k] = 1'b0;
            din[k] = '0;
            in_tag[k] = '0;
            out_ready[k] = 1'b1;
        end
        check("model_zero", model_raw(48'h0), 32'hEFA72C4D);
        check("model_ones", model_raw(48'hFFFF_FFFF_FFFF), 32'hD9CE3DCB);
        check("model_s2_ones", model_raw(48'h03F0_0000_0000), 32'hE9A72C4D);
        check("model_p_msb", model_p(32'h8000_0000), 32'h0080_0000);
        check("model_p_lsb", model_p(32'h0000_0001), 32'h0000_0800);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) check_reset(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            send(k, 48'h0, 4'h1);
            wait_out(k, lat);
            check($sformatf("lat_zero%0d", k), lat, LAT[k]);
            check($sformatf("dout_zero%0d", k), dout[k], dout_of(32'hEFA72C4D));
            check($sformatf("tag_zero%0d", k), out_tag[k], 4'h1);
            @(posedge clk);
            #1;
            send(k, 48'hFFFF_FFFF_FFFF, 4'h2);
            wait_out(k, lat);
            check($sformatf("lat_ones%0d", k), lat, LAT[k]);
            check($sformatf("dout_ones%0d", k), dout[k], dout_of(32'hD9CE3DCB));
            @(posedge clk);
            #1;
            send(k, 48'h03F0_0000_0000, 4'h3);
            wait_out(k, lat);
            check($sformatf("dout_s2%0d", k), dout[k], dout_of(32'hE9A72C4D));
            @(posedge clk);
            #1;
        end
        out_ready[3] = 1'b0;
        send(3, 48'h0, 4'h5);
        wait_out(3, lat);
        @(posedge clk);
        #1;
        in_valid[3] = 1'b1;
        din[3] = 48'hFFFF_FFFF_FFFF;
        in_tag[3] = 4'h6;
        repeat (10) begin
            @(negedge clk);
            check("hold_state", {out_valid[3], in_ready[3], out_tag[3]}, {1'b1, 1'b0, 4'h5});
            check("hold_dout", dout[3], dout_of(32'hEFA72C4D));
        end
        @(posedge clk);
        #1 in_valid[3] = 1'b0;
        out_ready[3] = 1'b1;
        @(posedge clk);
        #1;
        send(0, 48'hFFFF_FFFF_FFFF, 4'h7);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset(0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        check("no_stale_word", seen, 0);
        @(posedge clk);
        #1;
        send(0, 48'h0, 4'h8);
        wait_out(0, lat);
        check("post_reset_dout", {out_tag[0], dout[0]}, {4'h8, dout_of(32'hEFA72C4D)});
        @(posedge clk);
        #1 rnd_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat (250) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                rd = {16'($urandom), $urandom};
                send(k, rd, 4'($urandom));
            end
        end
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) out_ready[k] = 1'b1;
        repeat (20) @(posedge clk);
        end_chk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
